// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its 1-bit shift stage.
// The optional carry-out feature (cout port) is enabled by defining SHIFT_SEQ_COUT_EN.
package shift_pkg;

  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4,
    CLR = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] H_HOLD  = 2'b00;
  localparam logic [1:0] H_LEFT  = 2'b01;
  localparam logic [1:0] H_RIGHT = 2'b10;
  localparam logic [1:0] H_CLR   = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// Combinational 1-step universal shifter: hold, shift left (fill IL), shift right (fill IR), clear.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] f,
  input  logic [1:0]   h,
  input  logic         il,
  input  logic         ir,
  output logic [N-1:0] s
);

  always_comb begin
    s = f;
    case (h)
      H_HOLD:  s = f;
      H_LEFT:  s = {f[N-2:0], il};
      H_RIGHT: s = {ir, f[N-1:1]};
      H_CLR:   s = '0;
      default: s = f;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: loads an operand, then drives one shift_stage step per clock.
// Define SHIFT_SEQ_COUT_EN to add the cout port reporting the last bit shifted out.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [CW-1:0] amt,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done
`ifdef SHIFT_SEQ_COUT_EN
  ,
  output logic          cout
`endif
);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    op_r;
  logic          load, step;
  logic [1:0]    h;
  logic          il, ir;
  logic [N-1:0]  s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus per-step H/IL/IR decode of the latched operation
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    h       = H_HOLD;
    il      = 1'b0;
    ir      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (amt == '0 || op == 3'(CLR)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(1)) state_n = DONE;
        case (op_r)
          3'(LSL): h = H_LEFT;
          3'(LSR): h = H_RIGHT;
          3'(ASR): begin h = H_RIGHT; ir = q[N-1]; end
          3'(ROL): begin h = H_LEFT;  il = q[N-1]; end
          3'(ROR): begin h = H_RIGHT; ir = q[0];   end
          default: h = H_HOLD;
        endcase
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  shift_stage #(.N(N)) u_stage (
    .f  (q),
    .h  (h),
    .il (il),
    .ir (ir),
    .s  (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      cnt  <= '0;
      op_r <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
      if (load) begin
        q    <= (op == 3'(CLR)) ? '0 : d;
        cnt  <= amt;
        op_r <= op;
      end else begin
        q <= s;
        if (step) cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef SHIFT_SEQ_COUT_EN
  // Bit leaving q on each real step; undefined ops hold and leave cout untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout <= 1'b0;
    end else if (load) begin
      cout <= 1'b0;
    end else if (step && h != H_HOLD) begin
      cout <= (h == H_LEFT) ? q[N-1] : q[0];
    end
  end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (N=8, CW=4): directed table, random ops vs model, corner sequences.
// cout checks are compiled in only when SHIFT_SEQ_COUT_EN is defined.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [CW-1:0] amt;
  logic [N-1:0]  d;
  logic [N-1:0]  q;
  logic          busy, done;
`ifdef SHIFT_SEQ_COUT_EN
  logic          cout;
`endif

  int nchk = 0;
  int nerr = 0;

  shift_sequencer #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .d     (d),
    .q     (q),
    .busy  (busy),
    .done  (done)
`ifdef SHIFT_SEQ_COUT_EN
    ,
    .cout  (cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic [3:0] amt;
    logic [7:0] q;
    int         dc;
    logic       co;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference result from the shift rules using plain integer arithmetic
  function automatic logic [7:0] model_q(input logic [2:0] o, input logic [7:0] x, input int a);
    int v, sx, r;
    v = int'(x);
    case (o)
      3'(LSL): return (a >= 8) ? 8'h00 : 8'((v << a) & 255);
      3'(LSR): return (a >= 8) ? 8'h00 : 8'(v >> a);
      3'(ASR): begin
        sx = x[7] ? v - 256 : v;
        return 8'((sx >>> a) & 255);
      end
      3'(ROL): begin r = a % 8; return 8'(((v << r) | (v >> (8 - r))) & 255); end
      3'(ROR): begin r = a % 8; return 8'(((v >> r) | (v << (8 - r))) & 255); end
      3'(CLR): return 8'h00;
      default: return x;
    endcase
  endfunction

  function automatic logic model_cout(input logic [2:0] o, input logic [7:0] x, input int a);
    logic [7:0] res;
    res = model_q(o, x, a);
    if (a == 0) return 1'b0;
    case (o)
      3'(LSL): return (a <= 8) ? x[8 - a] : 1'b0;
      3'(LSR): return (a <= 8) ? x[a - 1] : 1'b0;
      3'(ASR): return (a <= 8) ? x[a - 1] : x[7];
      3'(ROL): return res[0];
      3'(ROR): return res[7];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_dc(input logic [2:0] o, input int a);
    return (a == 0 || o == 3'(CLR)) ? 1 : a + 1;
  endfunction

  // Issue one operation from IDLE and check done timing, busy length, result and cout
  task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] x,
                        input logic [3:0] a, input logic [7:0] eq, input int edc, input logic eco);
    int done_cyc, busy_n;
    logic [7:0] qd;
    @(posedge clk); #1;
    op = o; d = x; amt = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; d = 8'($urandom); amt = 4'($urandom); op = 3'($urandom);
    done_cyc = 0; busy_n = 0; qd = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_n++;
      if (done) begin done_cyc = c; qd = q; break; end
      @(posedge clk); #1;
    end
    chk({nm, " done_cycle"}, done_cyc, edc);
    chk({nm, " q"}, int'(qd), int'(eq));
    chk({nm, " busy_cycles"}, busy_n, edc);
`ifdef SHIFT_SEQ_COUT_EN
    chk({nm, " cout"}, int'(cout), int'(eco));
`else
    if (eco === 1'bx) $display("unreachable");
`endif
    @(posedge clk); #1;
    chk({nm, " idle_after"}, int'({busy, done}), 0);
    chk({nm, " q_hold"}, int'(q), int'(eq));
  endtask

  vec_t vt[$];
  int done_seen;
  logic [2:0] ro;
  logic [7:0] rd;
  logic [3:0] ra;

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; amt = '0; d = '0;
    #12;
    chk("reset_state", int'({q, busy, done}), 0);
`ifdef SHIFT_SEQ_COUT_EN
    chk("reset_cout", int'(cout), 0);
`endif
    @(negedge clk); reset = 1'b0;

    vt.push_back('{3'(LSL), 8'h96, 4'd3, 8'hB0, 4, 1'b0});
    vt.push_back('{3'(ASR), 8'h96, 4'd2, 8'hE5, 3, 1'b1});
    vt.push_back('{3'(LSR), 8'h96, 4'd2, 8'h25, 3, 1'b1});
    vt.push_back('{3'(ROR), 8'h96, 4'd1, 8'h4B, 2, 1'b0});
    vt.push_back('{3'(ROL), 8'h96, 4'd8, 8'h96, 9, 1'b0});
    vt.push_back('{3'(LSL), 8'h5A, 4'd0, 8'h5A, 1, 1'b0});
    vt.push_back('{3'(ROR), 8'hC3, 4'd0, 8'hC3, 1, 1'b0});
    vt.push_back('{3'(CLR), 8'hFF, 4'd7, 8'h00, 1, 1'b0});
    vt.push_back('{3'(LSL), 8'hFF, 4'd9, 8'h00, 10, 1'b0});
    vt.push_back('{3'(ASR), 8'h80, 4'd12, 8'hFF, 13, 1'b1});
    vt.push_back('{3'd7, 8'h3C, 4'd3, 8'h3C, 4, 1'b0});
    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].d, vt[i].amt, vt[i].q, vt[i].dc, vt[i].co);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      ra = 4'($urandom_range(0, 15));
      run_op($sformatf("rand%0d", i), ro, rd, ra, model_q(ro, rd, int'(ra)),
             model_dc(ro, int'(ra)), model_cout(ro, rd, int'(ra)));
    end

    // start pulsed mid-SHIFT must not disturb the running LSL
    @(posedge clk); #1;
    op = 3'(LSL); d = 8'h96; amt = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 3'(CLR); d = 8'hFF; amt = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ignore_start done", int'(done), 1);
    chk("ignore_start q", int'(q), 8'hB0);
    @(posedge clk); #1;
    chk("ignore_start idle", int'(busy), 0);

    // start held high: ignored in DONE, accepted again from IDLE
    op = 3'(ROR); d = 8'h96; amt = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    d = 8'h01;
    @(posedge clk); #1;
    chk("b2b done", int'({done, q}), int'({1'b1, 8'h4B}));
    @(posedge clk); #1;
    chk("b2b idle", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b reaccept", int'({busy, q}), int'({1'b1, 8'h01}));
    @(posedge clk); #1;
    chk("b2b second done", int'({done, q}), int'({1'b1, 8'h80}));
    @(posedge clk); #1;

    // asynchronous reset between edges aborts the operation with no done
    op = 3'(ROL); d = 8'hA5; amt = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_reset", int'({q, busy, done}), 0);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) reset = 1'b0;
      if (done) done_seen++;
    end
    chk("reset_no_done", done_seen, 0);
    chk("reset_idle", int'({q, busy}), 0);

    run_op("post_reset", 3'(ASR), 8'h96, 4'd2, 8'hE5, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
